// File: rtl/mac_accumulator_if.sv
// Operand-in, multiplier and result-out signals of the MAC accumulator.
// The slave modport is the accumulator's side; master is the side that
// feeds operands, returns products and consumes results.
interface mac_accumulator_if #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_x;
  logic [7:0]       in_y;
  logic             in_last;
  logic [7:0]       mul_x;
  logic [7:0]       mul_y;
  logic [15:0]      mul_product;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [LEN_W-1:0] out_count;
  logic             out_overflow;

  modport slave (
    input  in_valid, in_x, in_y, in_last, mul_product, out_ready,
    output in_ready, mul_x, mul_y, out_valid, out_sum, out_count, out_overflow
  );

  modport master (
    output in_valid, in_x, in_y, in_last, mul_product, out_ready,
    input  in_ready, mul_x, mul_y, out_valid, out_sum, out_count, out_overflow
  );
endinterface

// File: rtl/mac_accumulator.sv
// Dot-product accumulator behind an external 8x8 multiplier.
// Operand pairs are registered onto the multiplier inputs (stage 1); the
// combinational product is summed into a wide accumulator (stage 2).
// A last-flagged element closes the vector and parks the result in DONE.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   ACCUM | taking operand pairs; in_ready high unless a last pair is in
//         | stage 1
//   DONE  | result held on out_*, out_valid high, input stalled until
//         | the consumer takes it
module mac_accumulator #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input logic              clock,
  input logic              reset,
  mac_accumulator_if.slave bus
);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t           state_q, state_d;
  logic             op_valid, op_last;
  logic [7:0]       op_x, op_y;
  logic [ACC_W-1:0] acc;
  logic [LEN_W-1:0] cnt;
  logic             ovf;
  logic [ACC_W:0]   sum_next;
  logic [LEN_W-1:0] cnt_next;
  logic             ovf_next;
  logic             finish;
  logic             ready;
  logic             accept;

  // Product is zero-extended; the extra top bit of sum_next is the carry-out.
  assign sum_next = {1'b0, acc} + {{(ACC_W-15){1'b0}}, bus.mul_product};
  assign cnt_next = (cnt == '1) ? cnt : cnt + 1'b1;
  assign ovf_next = ovf | sum_next[ACC_W];
  assign finish   = op_valid & op_last;
  assign accept   = bus.in_valid & ready;

  assign bus.in_ready = ready;
  assign bus.mul_x    = op_x;
  assign bus.mul_y    = op_y;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= ACCUM;
    else       state_q <= state_d;
  end

  // Next state and handshake outputs; reset gates in_ready directly.
  always_comb begin
    state_d       = state_q;
    ready         = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      ACCUM: begin
        ready = ~finish & ~reset;
        if (finish) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // Stage 1: operand register; operands hold when nothing is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_valid <= 1'b0;
      op_last  <= 1'b0;
      op_x     <= '0;
      op_y     <= '0;
    end else if (accept) begin
      op_valid <= 1'b1;
      op_last  <= bus.in_last;
      op_x     <= bus.in_x;
      op_y     <= bus.in_y;
    end else begin
      op_valid <= 1'b0;
    end
  end

  // Stage 2: running sum, saturating count and sticky overflow.
  always_ff @(posedge clock) begin
    if (reset || finish) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (op_valid) begin
      acc <= sum_next[ACC_W-1:0];
      cnt <= cnt_next;
      ovf <= ovf_next;
    end
  end

  // Result registers, loaded with the closing element already folded in.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.out_sum      <= '0;
      bus.out_count    <= '0;
      bus.out_overflow <= 1'b0;
    end else if (finish) begin
      bus.out_sum      <= sum_next[ACC_W-1:0];
      bus.out_count    <= cnt_next;
      bus.out_overflow <= ovf_next;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: two instances (24/8 and 16/2 widths) share one
// stimulus stream; a reference model pushes expected results per vector and
// per-instance monitors compare whenever a result is presented.
module tb_mac_accumulator;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_x, in_y;
  logic       in_last;
  logic       out_ready;
  logic       rand_bp;

  int total = 0;
  int bad   = 0;

  typedef struct {
    longint sum;
    longint cnt;
    longint ovf;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  longint vec_sum;
  longint vec_n;
  logic [7:0] last_x, last_y;

  mac_accumulator_if #(.ACC_W(24), .LEN_W(8)) bus_a ();
  mac_accumulator_if #(.ACC_W(16), .LEN_W(2)) bus_b ();

  mac_accumulator #(.ACC_W(24), .LEN_W(8)) dut_a (.clock(clk), .reset(reset), .bus(bus_a));
  mac_accumulator #(.ACC_W(16), .LEN_W(2)) dut_b (.clock(clk), .reset(reset), .bus(bus_b));

  assign bus_a.in_valid    = in_valid;
  assign bus_a.in_x        = in_x;
  assign bus_a.in_y        = in_y;
  assign bus_a.in_last     = in_last;
  assign bus_a.out_ready   = out_ready;
  assign bus_a.mul_product = 16'(bus_a.mul_x) * 16'(bus_a.mul_y);
  assign bus_b.in_valid    = in_valid;
  assign bus_b.in_x        = in_x;
  assign bus_b.in_y        = in_y;
  assign bus_b.in_last     = in_last;
  assign bus_b.out_ready   = out_ready;
  assign bus_b.mul_product = 16'(bus_b.mul_x) * 16'(bus_b.mul_y);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d @%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input longint s, input longint n, input int aw, input int lw);
    exp_t   e;
    longint lim;
    longint cmax;
    lim   = longint'(1) << aw;
    cmax  = (longint'(1) << lw) - 1;
    e.sum = s % lim;
    e.ovf = (s >= lim) ? 1 : 0;
    e.cnt = (n > cmax) ? cmax : n;
    return e;
  endfunction

  // Issue one pair and wait (bounded) for it to be accepted; updates the model.
  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic last,
                      output int waits);
    logic rdy;
    bit   got;
    got      = 0;
    waits    = 0;
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    in_last  = last;
    while (!got && waits < 64) begin
      @(negedge clk);
      rdy = bus_a.in_ready;
      @(posedge clk);
      waits++;
      if (rdy && !reset) got = 1;
    end
    #1;
    in_valid = 1'b0;
    in_x     = 8'($urandom);
    in_y     = 8'($urandom);
    if (!got) begin
      chk("accept_timeout", 0, 1);
    end else begin
      last_x  = x;
      last_y  = y;
      vec_sum = vec_sum + longint'(x) * longint'(y);
      vec_n   = vec_n + 1;
      if (last) begin
        qa.push_back(mk(vec_sum, vec_n, 24, 8));
        qb.push_back(mk(vec_sum, vec_n, 16, 2));
        vec_sum = 0;
        vec_n   = 0;
      end
    end
  endtask

  // Called right after the last pair's accept edge: checks latency, the
  // input stall, `hold` cycles of backpressure, then the handshake.
  task automatic tail(input int hold);
    out_ready = 1'b0;
    @(negedge clk);
    chk("tail_op_valid_out", 32'(bus_a.out_valid), 0);
    chk("tail_op_in_ready", 32'(bus_a.in_ready), 0);
    @(posedge clk);
    #1;
    for (int k = 0; k <= hold; k++) begin
      out_ready = (k == hold);
      @(negedge clk);
      chk("tail_done_out_valid", 32'(bus_a.out_valid), 1);
      chk("tail_done_in_ready", 32'(bus_a.in_ready), 0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    chk("reset_gates_in_ready", 32'(bus_a.in_ready), 0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    vec_sum = 0;
    vec_n   = 0;
    last_x  = 8'd0;
    last_y  = 8'd0;
  endtask

  // Result monitors: compare every presented result against the queue head,
  // pop on handshake.
  always @(negedge clk) begin
    if (!reset && bus_a.out_valid) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_out_valid", 1, 0);
      end else begin
        ea = qa[0];
        chk("a_out_sum", longint'(bus_a.out_sum), ea.sum);
        chk("a_out_count", longint'(bus_a.out_count), ea.cnt);
        chk("a_out_overflow", longint'(bus_a.out_overflow), ea.ovf);
        if (out_ready) void'(qa.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && bus_b.out_valid) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_out_valid", 1, 0);
      end else begin
        eb = qb[0];
        chk("b_out_sum", longint'(bus_b.out_sum), eb.sum);
        chk("b_out_count", longint'(bus_b.out_count), eb.cnt);
        chk("b_out_overflow", longint'(bus_b.out_overflow), eb.ovf);
        if (out_ready) void'(qb.pop_front());
      end
    end
  end

  // Multiplier operands must track the most recently accepted pair.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus_a.mul_x !== last_x || bus_a.mul_y !== last_y) begin
        chk("a_mul_operands", longint'({bus_a.mul_x, bus_a.mul_y}), longint'({last_x, last_y}));
      end
      if (bus_b.mul_x !== last_x || bus_b.mul_y !== last_y) begin
        chk("b_mul_operands", longint'({bus_b.mul_x, bus_b.mul_y}), longint'({last_x, last_y}));
      end
    end
  end

  // Random consumer backpressure during the random phase.
  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int w, w1, w2, w3, w4, len, gap;
    logic [7:0] rx, ry;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_x      = 8'd0;
    in_y      = 8'd0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    rand_bp   = 1'b0;
    vec_sum   = 0;
    vec_n     = 0;
    last_x    = 8'd0;
    last_y    = 8'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus_a.in_ready), 0);
    chk("rst_out_valid", 32'(bus_a.out_valid), 0);
    chk("rst_mul_x", 32'(bus_a.mul_x), 0);
    chk("rst_mul_y", 32'(bus_a.mul_y), 0);
    chk("rst_out_sum", 32'(bus_a.out_sum), 0);
    chk("rst_out_count", 32'(bus_a.out_count), 0);
    chk("rst_out_overflow", 32'(bus_a.out_overflow), 0);
    chk("rst_b_out_valid", 32'(bus_b.out_valid), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_exit_in_ready", 32'(bus_a.in_ready), 1);
    @(posedge clk);
    #1;

    // Single element.
    send(8'd255, 8'd255, 1'b1, w);
    chk("single_wait", w, 1);
    tail(0);

    // Four back-to-back elements.
    send(8'd3, 8'd4, 1'b0, w1);
    send(8'd5, 8'd6, 1'b0, w2);
    send(8'd7, 8'd8, 1'b0, w3);
    send(8'd255, 8'd2, 1'b1, w4);
    chk("b2b_resume_wait", w1, 1);
    chk("b2b_wait2", w2, 1);
    chk("b2b_wait3", w3, 1);
    chk("b2b_wait4", w4, 1);
    tail(0);

    // Backpressure for five cycles, then resume one cycle after handshake.
    send(8'd3, 8'd4, 1'b0, w);
    send(8'd5, 8'd6, 1'b0, w);
    send(8'd7, 8'd8, 1'b0, w);
    send(8'd255, 8'd2, 1'b1, w);
    tail(5);
    send(8'd0, 8'd9, 1'b1, w);
    chk("bp_resume_wait", w, 1);
    tail(0);

    // Overflow in the narrow instance, then a clean vector clears it.
    send(8'd255, 8'd255, 1'b0, w);
    send(8'd255, 8'd255, 1'b1, w);
    tail(0);
    send(8'd1, 8'd1, 1'b1, w);
    tail(0);

    // Reset mid-vector discards the partial sum and the in-flight pair.
    send(8'd10, 8'd10, 1'b0, w);
    send(8'd20, 8'd20, 1'b0, w);
    pulse_reset();
    @(negedge clk);
    chk("post_reset_out_valid", 32'(bus_a.out_valid), 0);
    chk("post_reset_in_ready", 32'(bus_a.in_ready), 1);
    @(posedge clk);
    #1;
    send(8'd2, 8'd3, 1'b1, w);
    tail(0);

    // Count saturation in the narrow instance.
    for (int i = 0; i < 5; i++) send(8'd1, 8'd1, 1'(i == 4), w);
    tail(0);

    // Random vectors, random gaps, random consumer backpressure.
    out_ready = 1'b1;
    rand_bp   = 1'b1;
    for (int v = 0; v < 40; v++) begin
      len = (v == 7) ? 300 : $urandom_range(1, 6);
      for (int e = 0; e < len; e++) begin
        gap = $urandom_range(0, 3);
        if (gap == 3) repeat (2) @(posedge clk);
        #1;
        rx = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
        ry = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
        if ($urandom_range(0, 7) == 0) rx = 8'd0;
        send(rx, ry, 1'(e == len - 1), w);
      end
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    for (int i = 0; i < 200 && (qa.size() != 0 || qb.size() != 0); i++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("a_results_drained", qa.size(), 0);
    chk("b_results_drained", qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
